// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake bundle for sync_fifo.
//   data_in, w_en, r_en : requests and write data toward the FIFO
//   data_out            : registered read data
//   count, full, empty  : occupancy and status flags
//   master modport = producer/consumer side, slave modport = FIFO side
interface sync_fifo_if #(
   parameter int FIFO_data_size = 3,
   parameter int FIFO_addr_size = 2
);
   logic [FIFO_data_size-1:0] data_in;
   logic                      w_en;
   logic                      r_en;
   logic [FIFO_data_size-1:0] data_out;
   logic [FIFO_addr_size:0]   count;
   logic                      full;
   logic                      empty;
   modport master (output data_in, w_en, r_en, input data_out, count, full, empty);
   modport slave  (input data_in, w_en, r_en, output data_out, count, full, empty);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, full/empty flags and registered read data.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears pointers, count, data_out; not the memory)
//   bus  : sync_fifo_if slave port (data_in, w_en, r_en in; data_out, count, full, empty out)
module sync_fifo #(
   parameter int FIFO_data_size = 3,
   parameter int FIFO_addr_size = 2
) (
   input logic        clk,
   input logic        rst,
   sync_fifo_if.slave bus
);
   localparam logic [FIFO_addr_size:0] DEPTH = {1'b1, {FIFO_addr_size{1'b0}}};
   logic [FIFO_data_size-1:0] mem [DEPTH];
   logic [FIFO_addr_size-1:0] wptr, rptr;
   logic [FIFO_addr_size:0]   cnt;
   logic [FIFO_data_size-1:0] dout;
   logic                      full, empty, wa, ra;
   // flags come straight from count so they track it with no extra delay
   assign full  = cnt == DEPTH;
   assign empty = cnt == '0;
   // requests are qualified against the pre-edge flags; rejected ones vanish silently
   assign wa = bus.w_en && !full;
   assign ra = bus.r_en && !empty;
   // storage is never reset; a reset-cycle write is still discarded
   always_ff @(posedge clk)
      if (!rst && wa) mem[wptr] <= bus.data_in;
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         dout <= '0;
      end else begin
         if (wa) wptr <= wptr + 1'b1;
         if (ra) begin
            dout <= mem[rptr];
            rptr <= rptr + 1'b1;
         end
         cnt <= (wa && !ra) ? cnt + 1'b1 : (ra && !wa) ? cnt - 1'b1 : cnt;
      end
   end
   assign bus.data_out = dout;
   assign bus.count    = cnt;
   assign bus.full     = full;
   assign bus.empty    = empty;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus for sync_fifo, checked against a queue model.
module tb_sync_fifo;
   localparam int DW = 3;
   localparam int AW = 2;
   localparam int DEPTH = 1 << AW;
   logic clk = 0;
   logic rst = 1;
   int total = 0;
   int bad = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_dout = '0;
   sync_fifo_if #(.FIFO_data_size(DW), .FIFO_addr_size(AW)) bus ();
   sync_fifo #(.FIFO_data_size(DW), .FIFO_addr_size(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag);
      logic [AW:0] ec;
      ec = (AW + 1)'(q.size());
      total++;
      assert (bus.count === ec) else begin
         bad++;
         $error("FAIL %s count got=%0d exp=%0d", tag, bus.count, ec);
      end
      total++;
      assert (bus.full === (q.size() == DEPTH)) else begin
         bad++;
         $error("FAIL %s full got=%b exp=%b", tag, bus.full, q.size() == DEPTH);
      end
      total++;
      assert (bus.empty === (q.size() == 0)) else begin
         bad++;
         $error("FAIL %s empty got=%b exp=%b", tag, bus.empty, q.size() == 0);
      end
      total++;
      assert (bus.data_out === exp_dout) else begin
         bad++;
         $error("FAIL %s data_out got=%0d exp=%0d", tag, bus.data_out, exp_dout);
      end
   endtask

   // one clock: drive, let the edge happen, advance the model, check 1 time unit later
   task automatic step(input logic r_st, input logic w, input logic r, input logic [DW-1:0] d, input string tag);
      bit can_w, can_r;
      rst = r_st;
      bus.w_en = w;
      bus.r_en = r;
      bus.data_in = d;
      @(posedge clk);
      if (r_st) begin
         q.delete();
         exp_dout = '0;
      end else begin
         can_w = w && q.size() < DEPTH;
         can_r = r && q.size() > 0;
         if (can_r) exp_dout = q.pop_front();
         if (can_w) q.push_back(d);
      end
      #1;
      chk(tag);
   endtask

   initial begin
      bus.w_en = 0;
      bus.r_en = 0;
      bus.data_in = '0;
      step(1, 1, 1, 3'd5, "reset0");
      step(1, 1, 1, 3'd6, "reset1");
      for (int i = 1; i <= 5; i++) step(0, 1, 0, DW'(i), "fill");
      total++;
      assert (bus.full === 1'b1) else begin
         bad++;
         $error("FAIL overflow full got=%b exp=1", bus.full);
      end
      for (int i = 0; i < 5; i++) step(0, 0, 1, '0, "drain");
      total++;
      assert (bus.data_out === 3'd4) else begin
         bad++;
         $error("FAIL underflow data_out got=%0d exp=4", bus.data_out);
      end
      for (int i = 1; i <= 3; i++) step(0, 1, 0, DW'(i), "wrap_pre_w");
      for (int i = 0; i < 3; i++) step(0, 0, 1, '0, "wrap_pre_r");
      step(0, 1, 0, 3'd5, "wrap_w");
      step(0, 1, 0, 3'd6, "wrap_w");
      step(0, 1, 0, 3'd7, "wrap_w");
      step(0, 1, 0, 3'd0, "wrap_w");
      for (int i = 0; i < 4; i++) step(0, 0, 1, '0, "wrap_r");
      total++;
      assert (bus.data_out === 3'd0) else begin
         bad++;
         $error("FAIL wrap_last data_out got=%0d exp=0", bus.data_out);
      end
      step(0, 1, 0, 3'd1, "sim_pre");
      step(0, 1, 0, 3'd2, "sim_pre");
      for (int i = 3; i <= 5; i++) step(0, 1, 1, DW'(i), "sim_rw");
      step(0, 0, 1, '0, "sim_drain");
      step(0, 0, 1, '0, "sim_drain");
      step(0, 1, 1, 3'd6, "sim_empty");
      total++;
      assert (bus.data_out === 3'd5) else begin
         bad++;
         $error("FAIL sim_empty_hold data_out got=%0d exp=5", bus.data_out);
      end
      for (int i = 1; i <= 3; i++) step(0, 1, 0, DW'(i), "sim_fill");
      step(0, 1, 1, 3'd7, "sim_full");
      step(0, 1, 0, 3'd2, "mid_op");
      step(1, 1, 1, 3'd3, "mid_reset");
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), DW'($urandom), "random");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
